nic_cpu_responder: RTL and testbench

- Network interface controller that sits between the four-stage processor and its mesh router port.
- CPU side: responder to the processor's NIC bus (nicEn, nicWrEn, 2-bit address, 64-bit data each way).
- Router side: one injection channel and one ejection channel, each with send/ready handshakes.
- Each direction is buffered by a parameterised FIFO so the CPU and the network are decoupled.

---
 rtl/nic_cpu_responder.sv | 141 ++++++++++++++
 tb/tb_nic_cpu_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/nic_cpu_responder.sv
// NIC between the CPU's NIC bus and a mesh router port, with one FIFO per direction.
// Optional macro NIC_POLARITY_EN gates injection on the head packet's VC bit matching net_polarity.

module nic_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [0:DW-1] din,
  output logic [0:DW-1] head,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [0:DW-1] mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full    = (count_q == DEPTH[PW:0]);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // Both guards look only at registered state, so a push while full stays refused
  // even when a pop happens in the same cycle.
  assign push_ok = push & !full;
  assign pop_ok  = pop & !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok) mem_q[wr_ptr_q] <= din;
  end
endmodule

module nic_cpu_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:1]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);
  logic                  in_full, in_empty, in_pop, in_push;
  logic                  out_full, out_empty, out_pop, out_push;
  logic [0:DATA_WIDTH-1] in_head, out_head;
  logic                  cpu_rd, cpu_wr, head_ok;

  assign cpu_rd   = nicEn & !nicWrEn;
  assign cpu_wr   = nicEn & nicWrEn;
  assign in_pop   = cpu_rd & (addr == 2'b00);
  assign out_push = cpu_wr & (addr == 2'b10);

  assign net_ri   = reset & !in_full;
  assign in_push  = net_si & net_ri;

`ifdef NIC_POLARITY_EN
  // Bit 0 is the VC bit; a mismatched head blocks everything behind it.
  assign head_ok  = (out_head[0] == net_polarity);
`else
  logic unused_polarity;
  assign unused_polarity = net_polarity;
  assign head_ok  = 1'b1;
`endif

  assign net_so   = reset & !out_empty & head_ok;
  assign net_do   = net_so ? out_head : '0;
  assign out_pop  = net_so & net_ro;

  always_comb begin
    d_out = '0;
    if (reset && cpu_rd) begin
      case (addr)
        2'b00:   d_out = in_empty ? '0 : in_head;
        2'b01:   d_out = {{(DATA_WIDTH-1){1'b0}}, !in_empty};
        2'b11:   d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
        default: d_out = '0;
      endcase
    end
  end

  nic_fifo #(.DW(DATA_WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_push),
    .pop   (in_pop),
    .din   (net_di),
    .head  (in_head),
    .full  (in_full),
    .empty (in_empty)
  );

  nic_fifo #(.DW(DATA_WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .pop   (out_pop),
    .din   (d_in),
    .head  (out_head),
    .full  (out_full),
    .empty (out_empty)
  );
endmodule

// File: tb/tb_nic_cpu_responder.sv
// Directed bench for nic_cpu_responder (DATA_WIDTH=64, DEPTH=2).
// Define NIC_POLARITY_EN to also exercise the polarity gate.

module tb_nic_cpu_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in, d_out, net_di, net_do;
  logic        nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] PKT0 = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0] V1   = 64'h8000_0000_0000_00B1;
  localparam logic [63:0] V2   = 64'h8000_0000_0000_00B2;
  localparam logic [63:0] V3   = 64'h8000_0000_0000_00B3;

  nic_cpu_responder #(.DATA_WIDTH(64), .DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Inputs change just after the falling edge; one step spans one rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_rd(input logic [1:0] a, input logic [63:0] exp, input string tag);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    #1 check(tag, d_out, exp);
    step();
    nicEn = 1'b0;
  endtask

  task automatic cpu_wr(input logic [63:0] data);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = data;
    step();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  initial begin
    reset = 1'b0; addr = 2'b00; d_in = '0; net_di = '0;
    nicEn = 1'b0; nicWrEn = 1'b0; net_si = 1'b0; net_ro = 1'b0;
    net_polarity = 1'b1;
    @(negedge clk);
    step();
    // Outputs held low during reset, even with a read strobe asserted.
    nicEn = 1'b1; addr = 2'b01;
    #1;
    check("rst_ri", {63'd0, net_ri}, 64'd0);
    check("rst_so", {63'd0, net_so}, 64'd0);
    check("rst_do", net_do, 64'd0);
    check("rst_dout", d_out, 64'd0);
    nicEn = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("rel_ri", {63'd0, net_ri}, 64'd1);
    check("rel_so", {63'd0, net_so}, 64'd0);
    cpu_rd(2'b01, 64'd0, "rel_rd01");
    cpu_rd(2'b11, 64'd0, "rel_rd11");
    cpu_rd(2'b10, 64'd0, "rd10_zero");

    // Single injection with the router ready.
    net_ro = 1'b1;
    cpu_wr(PKT0);
    #1;
    check("inj_so", {63'd0, net_so}, 64'd1);
    check("inj_do", net_do, PKT0);
    step();
    check("inj_so_after", {63'd0, net_so}, 64'd0);
    check("inj_do_after", net_do, 64'd0);
    net_ro = 1'b0;

    // Ejection: three packets offered, only two fit.
    net_si = 1'b1; net_di = 64'h1;
    step();
    net_di = 64'h2;
    #1 check("ej_ri_1", {63'd0, net_ri}, 64'd1);
    step();
    net_di = 64'h3;
    #1 check("ej_ri_full", {63'd0, net_ri}, 64'd0);
    step();
    check("ej_ri_held", {63'd0, net_ri}, 64'd0);
    cpu_rd(2'b01, 64'd1, "ej_rd01");
    cpu_rd(2'b00, 64'h1, "ej_pop1");
    // Pop of 0x2 coincides with the router pushing 0x3.
    cpu_rd(2'b00, 64'h2, "ej_pop2");
    net_si = 1'b0;
    cpu_rd(2'b00, 64'h3, "ej_pop3");
    cpu_rd(2'b01, 64'd0, "ej_empty");
    cpu_rd(2'b00, 64'd0, "ej_rd_empty");

    // Out FIFO fill with router stalled; third write dropped while router pops.
    cpu_wr(V1);
    cpu_rd(2'b11, 64'd0, "of_not_full");
    cpu_wr(V2);
    cpu_rd(2'b11, 64'd1, "of_full");
    net_ro = 1'b1;
    #1 check("of_do_v1", net_do, V1);
    cpu_wr(V3);
    #1 check("of_do_v2", net_do, V2);
    step();
    check("of_v3_dropped", {63'd0, net_so}, 64'd0);
    net_ro = 1'b0;

    // Simultaneous router push and CPU pop on a 1-entry in_fifo.
    net_si = 1'b1; net_di = 64'h10;
    step();
    net_di = 64'h20;
    cpu_rd(2'b00, 64'h10, "sim_pop");
    net_si = 1'b0;
    cpu_rd(2'b01, 64'd1, "sim_cnt1");
    cpu_rd(2'b00, 64'h20, "sim_head");
    cpu_rd(2'b01, 64'd0, "sim_cnt0");

    // Reset mid-stream discards both FIFOs.
    net_si = 1'b1; net_di = 64'h55;
    step();
    net_si = 1'b0;
    cpu_wr(V1);
    net_si = 1'b1; net_ro = 1'b1; net_di = 64'h66;
    reset = 1'b0;
    #1;
    check("mid_rst_so", {63'd0, net_so}, 64'd0);
    check("mid_rst_ri", {63'd0, net_ri}, 64'd0);
    step();
    net_si = 1'b0; net_ro = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_so_empty", {63'd0, net_so}, 64'd0);
    cpu_rd(2'b01, 64'd0, "mid_in_empty");
    cpu_rd(2'b11, 64'd0, "mid_out_notfull");

`ifdef NIC_POLARITY_EN
    net_ro = 1'b1; net_polarity = 1'b0;
    cpu_wr(V1);
    #1 check("pol_block", {63'd0, net_so}, 64'd0);
    step();
    check("pol_held", {63'd0, net_so}, 64'd0);
    net_polarity = 1'b1;
    #1;
    check("pol_so", {63'd0, net_so}, 64'd1);
    check("pol_do", net_do, V1);
    step();
    check("pol_done", {63'd0, net_so}, 64'd0);
    net_ro = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
